ed25519_sigverify_dsdp_ctl: RTL and testbench
=============================================

# ed25519_sigverify_dsdp_ctl

Credit-based issue/collect controller that wraps the ed25519 dual-scalar double-point multiplier. The multiplier accepts requests with valid/ready but emits results with valid only, so results cannot be back-pressured. This block admits a request only when a result slot is guaranteed free. Results are captured into an internal FIFO and presented downstream on a valid/ready interface, so a stalling consumer never loses a result.

## Interface
- W_M, 64: opaque metadata width, carried with each request and result.
- W_P, 2552: request payload width (Ax,Ay,Az,At,ApGx,ApGy,ApGz,At 8×255, plus As,Gs 2×256), passed through unmodified.
- DEPTH, 8: result FIFO entries; power of two, ≥2. Also the credit pool size.
- W_C, $clog2(DEPTH+1): width of counters.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_v  in  1  upstream request valid.
- s_r  out  1  upstream request ready.
- s_m  in  W_M  request metadata.
- s_p  in  W_P  request payload.
- mul_v  out  1  request valid to multiplier.
- mul_r  in  1  multiplier ready.
- mul_m  out  W_M  metadata to multiplier (= s_m).
- mul_p  out  W_P  payload to multiplier (= s_p).
- res_v  in  1  multiplier result valid (single-cycle pulse per result, no ready).
- res_m  in  W_M  result metadata.
- res_C  in  1020  result {Ct,Cz,Cy,Cx}, Cx in bits [254:0].
- o_v  out  1  downstream result valid.
- o_r  in  1  downstream ready.
- o_m  out  W_M  result metadata.
- o_C  out  1020  result point, same packing as res_C.
- o_cred  out  W_C  free credits.
- o_err  out  1  sticky protocol error.

## Operation
- Credit counter `cred`:
  - Reset value DEPTH.
  - Issue = s_v & mul_r & (cred≠0); decrements cred.
  - Pop = o_v & o_r; increments cred.
  - Issue and pop in the same cycle leave cred unchanged.
  - cred never exceeds DEPTH and never goes below 0.
- Gating, all combinational and free of registers:
  - mul_v = s_v & (cred≠0).
  - s_r = mul_r & (cred≠0).
  - mul_m = s_m, mul_p = s_p.
- Result FIFO:
  - Depth DEPTH, width W_M+1020.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - A count register of W_C bits tracks occupancy.
  - Push when res_v = 1; pop when o_v & o_r.
  - Push and pop in the same cycle are both performed; count is unchanged.
- Output is show-ahead: o_v = (count≠0), and o_m/o_C show the head entry.
  - When o_v = 0, o_m/o_C hold the last head contents. Their value is don't-care.
- Invariant: cred + count + in_flight = DEPTH, where in_flight is the number of results issued but not yet returned.
- Errors:
  - res_v while count = DEPTH with no simultaneous pop: the result is dropped, o_err sets, and pointers and count are unchanged.
  - res_v while count + cred = DEPTH (no in-flight request): o_err sets and the result is still pushed if space allows.
  - o_err clears only on reset.
- Ordering: results leave in res_v arrival order. No reordering and no inspection of metadata.
- The multiplier shares rst. Asserting rst mid-operation discards all in-flight and buffered results.

## Timing
- Reset (async assert, sync-safe release) values:
  - cred = DEPTH, count = 0, pointers = 0, o_err = 0.
  - o_v = 0, so o_cred = DEPTH.
  - s_r = mul_r and mul_v = s_v, because of the combinational gating.
- Issue path has zero latency, combinational from s_v/mul_r/cred.
- Result to output: res_v at edge N makes o_v = 1 in the cycle after edge N. Latency is one cycle.
- A credit returned by a pop at edge N is usable for an issue in the cycle after edge N.
- Steady state: with o_r held high and a multiplier pipeline of depth L, throughput is 1 result/cycle provided DEPTH ≥ L+1. Otherwise throughput is DEPTH/(L+1).
- o_cred and o_err are registered.

## Test plan
- Reset then single request (s_m=0x1, mul_r=1), result returned 49 cycles later, o_r=1:
  - o_cred goes 8→7.
  - o_v high 1 cycle after res_v with o_m=0x1.
  - o_cred returns to 8 after the pop.
- Back-to-back saturation: s_v=1 for 20 cycles, no results returned:
  - Exactly 8 issues.
  - s_r=0 and mul_v=0 from the 9th cycle on.
  - o_cred=0.
- Downstream stall: 8 results arrive with o_r=0:
  - count=8 and o_v=1, with no o_err.
  - Raising o_r drains 8 entries in order m=0..7 over 8 cycles, with FIFO wrap exercised.
- Simultaneous issue, push and pop in one cycle at count=4, cred=2:
  - count stays 4 and cred stays 2.
  - Data order is preserved.
- Protocol error: inject res_v with no outstanding request:
  - o_err=1 next cycle and stays 1.
  - The entry is still delivered.
- Async reset asserted mid-stream with 3 results buffered and 2 in flight:
  - Immediately o_v=0, o_cred=8, o_err=0.
  - No stale results appear after release.

Source files
------------

// File: rtl/ed25519_sigverify_dsdp_ctl_if.sv
// Handshake and data bundle between the upstream requester, the ed25519
// dual-scalar multiplier and the downstream result consumer.
// "master" is the environment side; "slave" is the credit controller.
interface ed25519_sigverify_dsdp_ctl_if #(
  parameter int W_M   = 64,
  parameter int W_P   = 2552,
  parameter int DEPTH = 8,
  parameter int W_C   = $clog2(DEPTH + 1)
);
  // upstream request
  logic           s_v;
  logic           s_r;
  logic [W_M-1:0] s_m;
  logic [W_P-1:0] s_p;
  // request to multiplier
  logic           mul_v;
  logic           mul_r;
  logic [W_M-1:0] mul_m;
  logic [W_P-1:0] mul_p;
  // multiplier result (valid only, cannot stall)
  logic           res_v;
  logic [W_M-1:0] res_m;
  logic [1019:0]  res_C;
  // downstream result
  logic           o_v;
  logic           o_r;
  logic [W_M-1:0] o_m;
  logic [1019:0]  o_C;
  // status
  logic [W_C-1:0] o_cred;
  logic           o_err;

  modport master (
    output s_v, s_m, s_p, mul_r, res_v, res_m, res_C, o_r,
    input  s_r, mul_v, mul_m, mul_p, o_v, o_m, o_C, o_cred, o_err
  );

  modport slave (
    input  s_v, s_m, s_p, mul_r, res_v, res_m, res_C, o_r,
    output s_r, mul_v, mul_m, mul_p, o_v, o_m, o_C, o_cred, o_err
  );
endinterface

// File: rtl/ed25519_sigverify_dsdp_ctl.sv
// Credit-based issue/collect wrapper around the ed25519 dual-scalar
// double-point multiplier. A request is only admitted when a result slot is
// reserved for it, so the non-stallable multiplier output always lands in
// the result FIFO. The FIFO is show-ahead towards the downstream consumer.
module ed25519_sigverify_dsdp_ctl #(
  parameter int W_M   = 64,
  parameter int W_P   = 2552,
  parameter int DEPTH = 8,
  parameter int W_C   = $clog2(DEPTH + 1)
) (
  input logic                         clk,
  input logic                         rst,
  ed25519_sigverify_dsdp_ctl_if.slave bus
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int W_E = W_M + 1020;
  localparam logic [W_C-1:0] C_DEPTH   = W_C'(DEPTH);
  localparam logic [W_C:0]   C_DEPTH_X = (W_C + 1)'(DEPTH);

  logic [W_C-1:0] r_cred;
  logic [W_C-1:0] r_count;
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic           r_err;
  logic [W_E-1:0] r_mem [DEPTH];

  logic           w_cred_nz;
  logic           w_issue;
  logic           w_out_v;
  logic           w_pop;
  logic           w_full;
  logic           w_push;
  logic           w_err_ovf;
  logic           w_err_spur;
  logic [W_C:0]   w_occ_sum;
  logic [W_P-1:0] w_payload;
  logic [W_E-1:0] w_head;

  // Issue gating is purely combinational so a credit freed at an edge is
  // usable in the very next cycle.
  assign w_cred_nz = (r_cred != '0);
  assign w_issue   = bus.s_v & bus.mul_r & w_cred_nz;
  assign bus.mul_v = bus.s_v & w_cred_nz;
  assign bus.s_r   = bus.mul_r & w_cred_nz;
  assign bus.mul_m = bus.s_m;
  assign w_payload = bus.s_p;
  assign bus.mul_p = w_payload;

  assign w_out_v = (r_count != '0);
  assign w_pop   = w_out_v & bus.o_r;
  assign w_full  = (r_count == C_DEPTH);

  // A full FIFO can still take a result if the head leaves in the same cycle.
  assign w_push    = bus.res_v & (~w_full | w_pop);
  assign w_err_ovf = bus.res_v & w_full & ~w_pop;

  // count + cred == DEPTH means nothing is in flight, so any result is spurious.
  assign w_occ_sum  = {1'b0, r_count} + {1'b0, r_cred};
  assign w_err_spur = bus.res_v & (w_occ_sum == C_DEPTH_X);

  assign w_head     = r_mem[r_rptr];
  assign bus.o_v    = w_out_v;
  assign bus.o_m    = w_head[W_E-1 -: W_M];
  assign bus.o_C    = w_head[1019:0];
  assign bus.o_cred = r_cred;
  assign bus.o_err  = r_err;

  // Credit pool: issue takes one, pop returns one; saturates at DEPTH so a
  // spurious result cannot inflate the pool.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cred <= C_DEPTH;
    end else if (w_issue && !w_pop) begin
      r_cred <= r_cred - W_C'(1);
    end else if (w_pop && !w_issue && (r_cred != C_DEPTH)) begin
      r_cred <= r_cred + W_C'(1);
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + W_C'(1);
        2'b01:   r_count <= r_count - W_C'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Result storage; contents need no reset because the count gates validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.res_m, bus.res_C};
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_err_ovf || w_err_spur) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ed25519_sigverify_dsdp_ctl.sv
// Directed bench for the ed25519 sigverify credit controller.
module tb_ed25519_sigverify_dsdp_ctl;

  localparam int W_M   = 64;
  localparam int W_P   = 2552;
  localparam int DEPTH = 8;
  localparam int W_C   = $clog2(DEPTH + 1);

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;
  int   n_iss;

  ed25519_sigverify_dsdp_ctl_if #(.W_M(W_M), .W_P(W_P), .DEPTH(DEPTH), .W_C(W_C)) bus ();

  ed25519_sigverify_dsdp_ctl #(.W_M(W_M), .W_P(W_P), .DEPTH(DEPTH), .W_C(W_C)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_res(input logic [63:0] m);
    bus.res_v = 1'b1;
    bus.res_m = m;
    bus.res_C = {m ^ 64'hC0FFEE, 892'd0, m};
  endtask

  task automatic issue_n(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      bus.s_v = 1'b1;
      bus.s_m = base + 64'(i);
      tick();
    end
    bus.s_v = 1'b0;
  endtask

  task automatic return_n(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      drive_res(base + 64'(i));
      tick();
    end
    bus.res_v = 1'b0;
  endtask

  task automatic drain_n(input string tag, input int n, input logic [63:0] base);
    bus.o_r = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk_val({tag, "_ov"}, 64'(bus.o_v), 64'd1);
      chk_val({tag, "_om"}, bus.o_m, base + 64'(i));
      chk_val({tag, "_oc"}, bus.o_C[63:0], base + 64'(i));
      tick();
    end
    chk_val({tag, "_empty"}, 64'(bus.o_v), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.s_v = 1'b0; bus.s_m = '0; bus.s_p = '0; bus.mul_r = 1'b0;
    bus.res_v = 1'b0; bus.res_m = '0; bus.res_C = '0; bus.o_r = 1'b0;
    repeat (3) tick();

    // reset state
    chk_val("rst_ov", 64'(bus.o_v), 64'd0);
    chk_val("rst_cred", 64'(bus.o_cred), 64'd8);
    chk_val("rst_err", 64'(bus.o_err), 64'd0);
    chk_val("rst_sr", 64'(bus.s_r), 64'd0);
    rst = 1'b1;
    bus.s_v = 1'b1; bus.mul_r = 1'b0;
    #1;
    chk_val("gate_mulv", 64'(bus.mul_v), 64'd1);
    chk_val("gate_sr0", 64'(bus.s_r), 64'd0);
    bus.s_v = 1'b0; bus.mul_r = 1'b1;
    #1;
    chk_val("gate_sr1", 64'(bus.s_r), 64'd1);
    chk_val("gate_mulv0", 64'(bus.mul_v), 64'd0);
    tick();

    // single request, result 49 cycles later
    bus.s_v = 1'b1; bus.s_m = 64'h1; bus.s_p = {W_P{1'b0}} | W_P'(64'hABCD_1234);
    #1;
    chk_val("one_mulm", bus.mul_m, 64'h1);
    chk_val("one_mulp", bus.mul_p[63:0], 64'hABCD_1234);
    tick();
    bus.s_v = 1'b0;
    chk_val("one_cred7", 64'(bus.o_cred), 64'd7);
    repeat (48) tick();
    drive_res(64'h1);
    bus.o_r = 1'b1;
    tick();
    bus.res_v = 1'b0;
    chk_val("one_ov", 64'(bus.o_v), 64'd1);
    chk_val("one_om", bus.o_m, 64'h1);
    chk_val("one_oc_hi", bus.o_C[1019:956], 64'h1 ^ 64'hC0FFEE);
    tick();
    chk_val("one_ov0", 64'(bus.o_v), 64'd0);
    chk_val("one_cred8", 64'(bus.o_cred), 64'd8);

    // saturation: 20 cycles of s_v, no results
    n_iss = 0;
    for (int i = 0; i < 20; i++) begin
      bus.s_v = 1'b1;
      bus.s_m = 64'(i);
      #1;
      if (bus.s_v && bus.s_r) n_iss++;
      if (i == 8) begin
        chk_val("sat_sr9", 64'(bus.s_r), 64'd0);
        chk_val("sat_mulv9", 64'(bus.mul_v), 64'd0);
      end
      tick();
    end
    bus.s_v = 1'b0;
    chk_val("sat_issues", 64'(n_iss), 64'd8);
    chk_val("sat_cred0", 64'(bus.o_cred), 64'd0);

    // downstream stall, then in-order drain with pointer wrap
    bus.o_r = 1'b0;
    return_n(8, 64'h0);
    chk_val("stall_ov", 64'(bus.o_v), 64'd1);
    chk_val("stall_err", 64'(bus.o_err), 64'd0);
    chk_val("stall_cred", 64'(bus.o_cred), 64'd0);
    drain_n("drain", 8, 64'h0);
    chk_val("drain_cred", 64'(bus.o_cred), 64'd8);

    // simultaneous issue/push/pop at count=4 cred=2
    bus.o_r = 1'b0;
    issue_n(6, 64'h10);
    chk_val("sim_cred2a", 64'(bus.o_cred), 64'd2);
    return_n(4, 64'h10);
    bus.s_v = 1'b1; bus.s_m = 64'h16;
    drive_res(64'h14);
    bus.o_r = 1'b1;
    #1;
    chk_val("sim_sr", 64'(bus.s_r), 64'd1);
    chk_val("sim_head", bus.o_m, 64'h10);
    tick();
    bus.s_v = 1'b0; bus.res_v = 1'b0; bus.o_r = 1'b0;
    chk_val("sim_cred2b", 64'(bus.o_cred), 64'd2);
    drain_n("sim", 4, 64'h11);
    chk_val("sim_cred6", 64'(bus.o_cred), 64'd6);
    drive_res(64'h15);
    tick();
    drive_res(64'h16);
    chk_val("sim_h15", bus.o_m, 64'h15);
    tick();
    bus.res_v = 1'b0;
    chk_val("sim_h16", bus.o_m, 64'h16);
    tick();
    chk_val("sim_ov0", 64'(bus.o_v), 64'd0);
    chk_val("sim_cred8", 64'(bus.o_cred), 64'd8);
    chk_val("sim_err0", 64'(bus.o_err), 64'd0);

    // spurious result with nothing outstanding
    bus.o_r = 1'b0;
    drive_res(64'hEE);
    tick();
    bus.res_v = 1'b0;
    chk_val("spur_err", 64'(bus.o_err), 64'd1);
    chk_val("spur_ov", 64'(bus.o_v), 64'd1);
    chk_val("spur_om", bus.o_m, 64'hEE);
    bus.o_r = 1'b1;
    tick();
    chk_val("spur_ov0", 64'(bus.o_v), 64'd0);
    chk_val("spur_cred_sat", 64'(bus.o_cred), 64'd8);
    tick();
    chk_val("spur_sticky", 64'(bus.o_err), 64'd1);

    // async reset with 3 buffered and 2 in flight
    bus.o_r = 1'b0;
    issue_n(5, 64'h20);
    return_n(3, 64'h20);
    chk_val("ar_ov", 64'(bus.o_v), 64'd1);
    chk_val("ar_cred3", 64'(bus.o_cred), 64'd3);
    #2;
    rst = 1'b0;
    #1;
    chk_val("ar_ov0", 64'(bus.o_v), 64'd0);
    chk_val("ar_cred8", 64'(bus.o_cred), 64'd8);
    chk_val("ar_err0", 64'(bus.o_err), 64'd0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    bus.o_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_val("ar_nostale", 64'(bus.o_v), 64'd0);
      tick();
    end
    issue_n(1, 64'h30);
    chk_val("ar_post_cred7", 64'(bus.o_cred), 64'd7);
    drive_res(64'h30);
    tick();
    bus.res_v = 1'b0;
    chk_val("ar_post_ov", 64'(bus.o_v), 64'd1);
    chk_val("ar_post_om", bus.o_m, 64'h30);
    tick();
    chk_val("ar_post_ov0", 64'(bus.o_v), 64'd0);
    chk_val("ar_post_cred8", 64'(bus.o_cred), 64'd8);

    // overflow: result into a full FIFO is dropped and flagged
    bus.o_r = 1'b0;
    issue_n(8, 64'h40);
    return_n(8, 64'h40);
    chk_val("ovf_full_noerr", 64'(bus.o_err), 64'd0);
    drive_res(64'h99);
    tick();
    bus.res_v = 1'b0;
    chk_val("ovf_err", 64'(bus.o_err), 64'd1);
    drain_n("ovf", 8, 64'h40);
    chk_val("ovf_cred8", 64'(bus.o_cred), 64'd8);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
